wbu: RTL and testbench
======================

Name: wbu

Overview:
Write-back/commit stage that sits directly downstream of the load-store stage. It accepts one retired-instruction packet per valid/ready handshake and performs the GPR write and the CSR write. For ecall it also writes mepc/mcause. It computes the next PC, counts retired instructions, and offers the next PC to the fetch stage over a valid/ready handshake.

Parameters:
CPU_WIDTH, 32, datapath/PC width
RESET_PC, 32'h8000_0000, value of o_npc after reset
ECALL_CAUSE, 32'd11, value written to mcause on ecall (M-mode environment call)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
i_pre_valid  input  1  upstream packet valid
o_pre_ready  output  1  wbu can accept a packet
o_post_valid  output  1  o_npc valid toward fetch stage
i_post_ready  input  1  fetch stage accepts o_npc
i_wbu_pc  input  CPU_WIDTH  PC of instruction
i_wbu_imm  input  CPU_WIDTH  immediate
i_wbu_rs1  input  CPU_WIDTH  rs1 value (jalr base)
i_wbu_is_jal  input  1  jal
i_wbu_is_jalr  input  1  jalr
i_wbu_brch  input  1  branch taken
i_wbu_csr_npc  input  CPU_WIDTH  trap/return target (mtvec or mepc)
i_wbu_is_ejump  input  1  mret or ecall
i_wbu_is_ecall  input  1  ecall
i_wbu_rd  input  CPU_WIDTH  GPR write data
i_wbu_rd_id  input  5  GPR index
i_wbu_gpr_wen  input  1  GPR write request
i_wbu_csr_wen  input  1  CSR write request
i_wbu_csr_wid  input  12  CSR address
i_wbu_csr_rd  input  CPU_WIDTH  CSR write data
o_gpr_wen / o_gpr_waddr / o_gpr_wdata  output  1/5/CPU_WIDTH  register-file write port
o_csr_wen / o_csr_waddr / o_csr_wdata  output  1/12/CPU_WIDTH  CSR write port
o_trap_wen  output  1  ecall pulse: write mepc and mcause
o_mepc / o_mcause  output  CPU_WIDTH  ecall trap values
o_npc  output  CPU_WIDTH  next PC
o_instret  output  64  retired-instruction count

Behaviour:
- State machine: IDLE, COMMIT, HOLD.
- Reset (rst low, asynchronous):
  - state = IDLE; captured packet cleared.
  - All write enables = 0; o_post_valid = 0; o_npc = RESET_PC; o_instret = 0; all data outputs = 0.
  - o_pre_ready forced to 0 while rst is low.
- Port relations:
  - o_pre_ready = (state == IDLE) and rst high.
  - o_post_valid = (state == COMMIT or HOLD).
- IDLE: when i_pre_valid = 1, the packet is registered on the clock edge and the state goes to COMMIT. Otherwise stay in IDLE.
- COMMIT (exactly one cycle per packet):
  - o_gpr_wen = gpr_wen AND (rd_id != 0). A write to x0 is always suppressed.
  - o_csr_wen = csr_wen.
  - o_trap_wen = is_ecall, with o_mepc = pc and o_mcause = ECALL_CAUSE.
  - If i_post_ready = 1: go to IDLE. Otherwise go to HOLD.
- HOLD:
  - No write enables asserted; register and CSR writes are never repeated.
  - o_npc and o_post_valid are held stable.
  - Go to IDLE when i_post_ready = 1.
- o_npc is registered and updated on the IDLE→COMMIT edge. Priority, all arithmetic mod 2^32:
  1. is_ejump → csr_npc
  2. is_jal → pc + imm
  3. is_jalr → (rs1 + imm) & ~1
  4. brch → pc + imm
  5. otherwise → pc + 4
- o_instret increments by 1 on each cycle where o_post_valid & i_post_ready. It wraps from 2^64−1 to 0.
- Latency:
  - Packet accepted at edge N; writes and o_post_valid visible in cycle N+1.
  - Maximum throughput is 1 packet per 2 cycles.
- Simultaneous events:
  - i_pre_valid is ignored in COMMIT and HOLD (o_pre_ready = 0), so packets are never lost or overwritten.
  - Multiple jump flags set at once are resolved by the priority above.
  - csr_wen and is_ecall in the same packet: both ports fire in the same cycle.
- Reset mid-operation: an in-flight packet is discarded with no write; o_instret is cleared.

Test Plan:
- Reset release: rst low for 3 cycles, then high → o_npc = 0x8000_0000, o_instret = 0, o_pre_ready = 1, o_post_valid = 0, all write enables 0.
- ALU op: pc = 0x8000_0010, gpr_wen = 1, rd_id = 5, rd = 0x1234, i_post_ready = 1 → single-cycle o_gpr_wen with waddr = 5, wdata = 0x1234; o_npc = 0x8000_0014; o_instret = 1.
- x0 and jalr: rd_id = 0, gpr_wen = 1, is_jalr = 1, rs1 = 0x8000_0101, imm = 4 → o_gpr_wen stays 0; o_npc = 0x8000_0104.
- Backpressure: branch with pc = 0x8000_0020, imm = 0xFFFF_FFF0, i_post_ready low for 4 cycles → o_npc = 0x8000_0010 held stable; exactly one write pulse; o_pre_ready = 0 throughout; o_instret increments once, on ready.
- ecall: pc = 0x8000_0040, is_ecall = 1, is_ejump = 1, csr_npc = 0x8000_0200 → o_trap_wen pulse with o_mepc = 0x8000_0040, o_mcause = 11; o_npc = 0x8000_0200.
- Async reset while in HOLD: assert rst between clock edges → o_post_valid drops immediately; no further writes; o_npc = RESET_PC.

Source files
------------

// File: rtl/wbu_if.sv
// Write-back stage bus: upstream packet handshake, fetch-side next-PC handshake,
// and the register-file / CSR / trap write ports.
interface wbu_if #(
    parameter int CPU_WIDTH = 32
);
    logic                 i_pre_valid;
    logic                 o_pre_ready;
    logic                 o_post_valid;
    logic                 i_post_ready;

    logic [CPU_WIDTH-1:0] i_wbu_pc;
    logic [CPU_WIDTH-1:0] i_wbu_imm;
    logic [CPU_WIDTH-1:0] i_wbu_rs1;
    logic                 i_wbu_is_jal;
    logic                 i_wbu_is_jalr;
    logic                 i_wbu_brch;
    logic [CPU_WIDTH-1:0] i_wbu_csr_npc;
    logic                 i_wbu_is_ejump;
    logic                 i_wbu_is_ecall;
    logic [CPU_WIDTH-1:0] i_wbu_rd;
    logic [4:0]           i_wbu_rd_id;
    logic                 i_wbu_gpr_wen;
    logic                 i_wbu_csr_wen;
    logic [11:0]          i_wbu_csr_wid;
    logic [CPU_WIDTH-1:0] i_wbu_csr_rd;

    logic                 o_gpr_wen;
    logic [4:0]           o_gpr_waddr;
    logic [CPU_WIDTH-1:0] o_gpr_wdata;
    logic                 o_csr_wen;
    logic [11:0]          o_csr_waddr;
    logic [CPU_WIDTH-1:0] o_csr_wdata;
    logic                 o_trap_wen;
    logic [CPU_WIDTH-1:0] o_mepc;
    logic [CPU_WIDTH-1:0] o_mcause;
    logic [CPU_WIDTH-1:0] o_npc;
    logic [63:0]          o_instret;

    modport slave (
        input  i_pre_valid, i_post_ready,
        input  i_wbu_pc, i_wbu_imm, i_wbu_rs1, i_wbu_is_jal, i_wbu_is_jalr,
        input  i_wbu_brch, i_wbu_csr_npc, i_wbu_is_ejump, i_wbu_is_ecall,
        input  i_wbu_rd, i_wbu_rd_id, i_wbu_gpr_wen, i_wbu_csr_wen,
        input  i_wbu_csr_wid, i_wbu_csr_rd,
        output o_pre_ready, o_post_valid,
        output o_gpr_wen, o_gpr_waddr, o_gpr_wdata,
        output o_csr_wen, o_csr_waddr, o_csr_wdata,
        output o_trap_wen, o_mepc, o_mcause, o_npc, o_instret
    );

    modport master (
        output i_pre_valid, i_post_ready,
        output i_wbu_pc, i_wbu_imm, i_wbu_rs1, i_wbu_is_jal, i_wbu_is_jalr,
        output i_wbu_brch, i_wbu_csr_npc, i_wbu_is_ejump, i_wbu_is_ecall,
        output i_wbu_rd, i_wbu_rd_id, i_wbu_gpr_wen, i_wbu_csr_wen,
        output i_wbu_csr_wid, i_wbu_csr_rd,
        input  o_pre_ready, o_post_valid,
        input  o_gpr_wen, o_gpr_waddr, o_gpr_wdata,
        input  o_csr_wen, o_csr_waddr, o_csr_wdata,
        input  o_trap_wen, o_mepc, o_mcause, o_npc, o_instret
    );
endinterface

// File: rtl/wbu.sv
// Write-back/commit: GPR/CSR/trap writes, next-PC selection, retire counter.
// Latency 1 cycle from accept to writes; stalls in HOLD (writes not repeated) until fetch takes o_npc.
module wbu #(
    parameter int                   CPU_WIDTH   = 32,
    parameter logic [CPU_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
    parameter logic [CPU_WIDTH-1:0] ECALL_CAUSE = 32'd11
) (
    input logic   clk,
    input logic   rst,
    wbu_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] HOLD   = 2'd2;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] pc;
        logic [CPU_WIDTH-1:0] rd;
        logic [4:0]           rd_id;
        logic                 gpr_wen;
        logic                 csr_wen;
        logic [11:0]          csr_wid;
        logic [CPU_WIDTH-1:0] csr_rd;
        logic                 is_ecall;
    } pkt_t;

    logic [1:0]           state_q, state_d;
    pkt_t                 pkt_q, pkt_d;
    logic [CPU_WIDTH-1:0] npc_q, npc_d;
    logic [63:0]          instret_q, instret_d;

    logic                 pre_ready;
    logic                 post_valid;
    logic                 accept;
    logic                 retire;
    logic                 in_commit;
    logic [CPU_WIDTH-1:0] pc_imm;
    logic [CPU_WIDTH-1:0] rs1_imm;
    logic [CPU_WIDTH-1:0] next_pc;

    assign pre_ready  = (state_q == IDLE) && rst;
    assign post_valid = (state_q == COMMIT) || (state_q == HOLD);
    assign in_commit  = (state_q == COMMIT);
    assign accept     = pre_ready && bus.i_pre_valid;
    assign retire     = post_valid && bus.i_post_ready;

    assign pc_imm  = bus.i_wbu_pc + bus.i_wbu_imm;
    assign rs1_imm = bus.i_wbu_rs1 + bus.i_wbu_imm;

    always_comb begin
        next_pc = bus.i_wbu_pc + CPU_WIDTH'(4);
        if (bus.i_wbu_is_ejump) begin
            next_pc = bus.i_wbu_csr_npc;
        end else if (bus.i_wbu_is_jal) begin
            next_pc = pc_imm;
        end else if (bus.i_wbu_is_jalr) begin
            next_pc = rs1_imm & ~CPU_WIDTH'(1);
        end else if (bus.i_wbu_brch) begin
            next_pc = pc_imm;
        end
    end

    always_comb begin
        state_d   = state_q;
        pkt_d     = pkt_q;
        npc_d     = npc_q;
        instret_d = instret_q;

        case (state_q)
            IDLE:    if (bus.i_pre_valid) state_d = COMMIT;
            COMMIT:  state_d = bus.i_post_ready ? IDLE : HOLD;
            HOLD:    if (bus.i_post_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            pkt_d.pc       = bus.i_wbu_pc;
            pkt_d.rd       = bus.i_wbu_rd;
            pkt_d.rd_id    = bus.i_wbu_rd_id;
            pkt_d.gpr_wen  = bus.i_wbu_gpr_wen;
            pkt_d.csr_wen  = bus.i_wbu_csr_wen;
            pkt_d.csr_wid  = bus.i_wbu_csr_wid;
            pkt_d.csr_rd   = bus.i_wbu_csr_rd;
            pkt_d.is_ecall = bus.i_wbu_is_ecall;
            npc_d          = next_pc;
        end

        if (retire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pkt_q     <= '0;
            npc_q     <= RESET_PC;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pkt_q     <= pkt_d;
            npc_q     <= npc_d;
            instret_q <= instret_d;
        end
    end

    assign bus.o_pre_ready  = pre_ready;
    assign bus.o_post_valid = post_valid;

    // Enables qualify on COMMIT only, so a stall in HOLD never replays a write.
    assign bus.o_gpr_wen   = in_commit && pkt_q.gpr_wen && (pkt_q.rd_id != 5'd0);
    assign bus.o_gpr_waddr = pkt_q.rd_id;
    assign bus.o_gpr_wdata = pkt_q.rd;

    assign bus.o_csr_wen   = in_commit && pkt_q.csr_wen;
    assign bus.o_csr_waddr = pkt_q.csr_wid;
    assign bus.o_csr_wdata = pkt_q.csr_rd;

    assign bus.o_trap_wen  = in_commit && pkt_q.is_ecall;
    assign bus.o_mepc      = bus.o_trap_wen ? pkt_q.pc : '0;
    assign bus.o_mcause    = bus.o_trap_wen ? ECALL_CAUSE : '0;

    assign bus.o_npc       = npc_q;
    assign bus.o_instret   = instret_q;
endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: reset, ALU commit, x0/jalr, backpressure, ecall, priority, async reset in HOLD.
module tb_wbu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    int   pulses;

    wbu_if #(.CPU_WIDTH(32)) bus ();

    wbu #(
        .CPU_WIDTH  (32),
        .RESET_PC   (32'h8000_0000),
        .ECALL_CAUSE(32'd11)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_pkt();
        bus.i_pre_valid    = 1'b0;
        bus.i_wbu_pc       = '0;
        bus.i_wbu_imm      = '0;
        bus.i_wbu_rs1      = '0;
        bus.i_wbu_is_jal   = 1'b0;
        bus.i_wbu_is_jalr  = 1'b0;
        bus.i_wbu_brch     = 1'b0;
        bus.i_wbu_csr_npc  = '0;
        bus.i_wbu_is_ejump = 1'b0;
        bus.i_wbu_is_ecall = 1'b0;
        bus.i_wbu_rd       = '0;
        bus.i_wbu_rd_id    = '0;
        bus.i_wbu_gpr_wen  = 1'b0;
        bus.i_wbu_csr_wen  = 1'b0;
        bus.i_wbu_csr_wid  = '0;
        bus.i_wbu_csr_rd   = '0;
    endtask

    // Hold the packet (already placed on the bus) valid across one edge, then
    // return at #1 after that edge, when the DUT is in COMMIT.
    task automatic push();
        bus.i_pre_valid = 1'b1;
        @(posedge clk);
        #1;
        clear_pkt();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        clear_pkt();
        bus.i_post_ready = 1'b1;

        // Reset held, then released
        repeat (3) @(posedge clk);
        #1;
        check("rst_pre_ready_low", 64'(bus.o_pre_ready), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_npc",        64'(bus.o_npc), 64'h8000_0000);
        check("rst_instret",    bus.o_instret, 64'd0);
        check("rst_pre_ready",  64'(bus.o_pre_ready), 64'd1);
        check("rst_post_valid", 64'(bus.o_post_valid), 64'd0);
        check("rst_gpr_wen",    64'(bus.o_gpr_wen), 64'd0);
        check("rst_csr_wen",    64'(bus.o_csr_wen), 64'd0);
        check("rst_trap_wen",   64'(bus.o_trap_wen), 64'd0);
        check("rst_mcause",     64'(bus.o_mcause), 64'd0);

        // ALU op: pc+4, single GPR write
        bus.i_wbu_pc      = 32'h8000_0010;
        bus.i_wbu_gpr_wen = 1'b1;
        bus.i_wbu_rd_id   = 5'd5;
        bus.i_wbu_rd      = 32'h1234;
        push();
        check("alu_gpr_wen",    64'(bus.o_gpr_wen), 64'd1);
        check("alu_gpr_waddr",  64'(bus.o_gpr_waddr), 64'd5);
        check("alu_gpr_wdata",  64'(bus.o_gpr_wdata), 64'h1234);
        check("alu_npc",        64'(bus.o_npc), 64'h8000_0014);
        check("alu_post_valid", 64'(bus.o_post_valid), 64'd1);
        check("alu_pre_ready",  64'(bus.o_pre_ready), 64'd0);
        check("alu_csr_wen",    64'(bus.o_csr_wen), 64'd0);
        step();
        check("alu_gpr_wen_off", 64'(bus.o_gpr_wen), 64'd0);
        check("alu_instret",     bus.o_instret, 64'd1);
        check("alu_idle_ready",  64'(bus.o_pre_ready), 64'd1);
        check("alu_idle_pvalid", 64'(bus.o_post_valid), 64'd0);

        // x0 write suppressed, jalr clears bit 0
        bus.i_wbu_gpr_wen = 1'b1;
        bus.i_wbu_rd_id   = 5'd0;
        bus.i_wbu_rd      = 32'hDEAD;
        bus.i_wbu_is_jalr = 1'b1;
        bus.i_wbu_rs1     = 32'h8000_0101;
        bus.i_wbu_imm     = 32'd4;
        bus.i_wbu_pc      = 32'h8000_0014;
        push();
        check("x0_gpr_wen", 64'(bus.o_gpr_wen), 64'd0);
        check("jalr_npc",   64'(bus.o_npc), 64'h8000_0104);
        step();
        check("jalr_instret", bus.o_instret, 64'd2);

        // Backpressure on a taken branch with negative offset
        bus.i_post_ready  = 1'b0;
        bus.i_wbu_pc      = 32'h8000_0020;
        bus.i_wbu_imm     = 32'hFFFF_FFF0;
        bus.i_wbu_brch    = 1'b1;
        bus.i_wbu_gpr_wen = 1'b1;
        bus.i_wbu_rd_id   = 5'd7;
        bus.i_wbu_rd      = 32'h77;
        bus.i_pre_valid   = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        // Keep a second packet offered: it must not be taken while stalled.
        bus.i_wbu_pc = 32'h8000_0900;
        for (int i = 0; i < 4; i++) begin
            if (bus.o_gpr_wen) pulses++;
            check("bp_npc",        64'(bus.o_npc), 64'h8000_0010);
            check("bp_pre_ready",  64'(bus.o_pre_ready), 64'd0);
            check("bp_post_valid", 64'(bus.o_post_valid), 64'd1);
            check("bp_instret",    bus.o_instret, 64'd2);
            step();
        end
        clear_pkt();
        bus.i_post_ready = 1'b1;
        #1;
        if (bus.o_gpr_wen) pulses++;
        step();
        check("bp_one_pulse",   64'(pulses), 64'd1);
        check("bp_instret_inc", bus.o_instret, 64'd3);
        check("bp_npc_after",   64'(bus.o_npc), 64'h8000_0010);
        check("bp_idle",        64'(bus.o_post_valid), 64'd0);

        // ecall with a CSR write in the same packet; ejump beats jal
        bus.i_wbu_pc       = 32'h8000_0040;
        bus.i_wbu_is_ecall = 1'b1;
        bus.i_wbu_is_ejump = 1'b1;
        bus.i_wbu_is_jal   = 1'b1;
        bus.i_wbu_imm      = 32'h100;
        bus.i_wbu_csr_npc  = 32'h8000_0200;
        bus.i_wbu_csr_wen  = 1'b1;
        bus.i_wbu_csr_wid  = 12'h300;
        bus.i_wbu_csr_rd   = 32'hABCD;
        push();
        check("ecall_trap_wen",  64'(bus.o_trap_wen), 64'd1);
        check("ecall_mepc",      64'(bus.o_mepc), 64'h8000_0040);
        check("ecall_mcause",    64'(bus.o_mcause), 64'd11);
        check("ecall_npc",       64'(bus.o_npc), 64'h8000_0200);
        check("ecall_csr_wen",   64'(bus.o_csr_wen), 64'd1);
        check("ecall_csr_waddr", 64'(bus.o_csr_waddr), 64'h300);
        check("ecall_csr_wdata", 64'(bus.o_csr_wdata), 64'hABCD);
        step();
        check("ecall_trap_off", 64'(bus.o_trap_wen), 64'd0);
        check("ecall_instret",  bus.o_instret, 64'd4);

        // jal beats jalr and branch
        bus.i_wbu_pc      = 32'h8000_0100;
        bus.i_wbu_imm     = 32'h20;
        bus.i_wbu_is_jal  = 1'b1;
        bus.i_wbu_is_jalr = 1'b1;
        bus.i_wbu_brch    = 1'b1;
        bus.i_wbu_rs1     = 32'h0000_1000;
        push();
        check("jal_npc", 64'(bus.o_npc), 64'h8000_0120);
        step();
        check("jal_instret", bus.o_instret, 64'd5);

        // Async reset while stalled in HOLD
        bus.i_post_ready  = 1'b0;
        bus.i_wbu_pc      = 32'h8000_0300;
        bus.i_wbu_gpr_wen = 1'b1;
        bus.i_wbu_rd_id   = 5'd3;
        bus.i_wbu_rd      = 32'h33;
        push();
        step();
        check("hold_post_valid", 64'(bus.o_post_valid), 64'd1);
        check("hold_gpr_wen",    64'(bus.o_gpr_wen), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_post_valid", 64'(bus.o_post_valid), 64'd0);
        check("arst_npc",        64'(bus.o_npc), 64'h8000_0000);
        check("arst_instret",    bus.o_instret, 64'd0);
        check("arst_pre_ready",  64'(bus.o_pre_ready), 64'd0);
        step();
        rst_n = 1'b1;
        bus.i_post_ready = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (bus.o_gpr_wen || bus.o_csr_wen || bus.o_trap_wen) pulses++;
            step();
        end
        check("arst_no_writes", 64'(pulses), 64'd0);
        check("arst_ready",     64'(bus.o_pre_ready), 64'd1);
        check("arst_instret2",  bus.o_instret, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
